// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters, the round-robin arbiter and
// one downstream consumer. The slave modport is the arbiter side.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic [7:0]       xfer_count;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, sel, out_valid, out_data, out_src, xfer_count
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, sel, out_valid, out_data, out_src, xfer_count
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux feeding a single output register
// stage; sustains one word per cycle and is safe under consumer backpressure.
module mux4_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mux4_rr_arbiter_if.slave    bus
);
  logic [1:0]       ptr_reg, ptr_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [1:0]       out_src_reg, out_src_next;
  logic [7:0]       xfer_count_reg, xfer_count_next;

  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             any_req;
  logic             free;
  logic             load;
  logic [3:0]       ready_vec;
  logic [WIDTH-1:0] data_arr [4];

  assign data_arr[0] = bus.in_data0;
  assign data_arr[1] = bus.in_data1;
  assign data_arr[2] = bus.in_data2;
  assign data_arr[3] = bus.in_data3;

  assign any_req = |bus.in_valid;
  assign free    = !out_valid_reg || bus.out_ready;
  assign load    = any_req && free && reset_n;

  // Scan from lowest to highest priority so the last hit is the winner;
  // with no request the winner falls back to ptr, which is what sel shows.
  always_comb begin
    winner = ptr_reg;
    idx    = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_reg + 2'(k);
      if (bus.in_valid[idx]) begin
        winner = idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ready
      assign ready_vec[gi] = load && (winner == 2'(gi));
    end
  endgenerate

  assign bus.in_ready   = ready_vec;
  assign bus.sel        = reset_n ? winner : 2'd0;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_src    = out_src_reg;
  assign bus.xfer_count = xfer_count_reg;

  always_comb begin
    ptr_next        = ptr_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_src_next    = out_src_reg;
    xfer_count_next = xfer_count_reg;
    if (load) begin
      // A load in FULL with out_ready high overwrites the word being drained.
      out_valid_next  = 1'b1;
      out_data_next   = data_arr[winner];
      out_src_next    = winner;
      ptr_next        = winner + 2'd1;
      xfer_count_next = xfer_count_reg + 8'd1;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg        <= 2'd0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_src_reg    <= 2'd0;
      xfer_count_reg <= 8'd0;
    end else begin
      ptr_reg        <= ptr_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_src_reg    <= out_src_next;
      xfer_count_reg <= xfer_count_next;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random
// traffic compared against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;
  logic clk;
  logic reset_n;

  mux4_rr_arbiter_if #(.WIDTH(4)) bus ();

  mux4_rr_arbiter #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int check_count = 0;
  int error_count = 0;

  // Behavioural model state
  int m_ptr, m_ov, m_od, m_os, m_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_od = 0; m_os = 0; m_cnt = 0;
  endtask

  // Called shortly after a rising edge: sel with no request exposes ptr.
  task automatic chk_ptr(input string tag);
    logic [3:0] saved;
    saved = bus.in_valid;
    bus.in_valid = 4'b0000;
    #1;
    chk(tag, 32'(bus.sel), 32'(m_ptr));
    bus.in_valid = saved;
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_src", 32'(bus.out_src), 0);
    chk("rst_xfer_count", 32'(bus.xfer_count), 0);
    chk("rst_sel", 32'(bus.sel), 0);
    reset_n = 1'b1;
    bus.in_valid = 4'h0;
  endtask

  // One clock cycle of traffic; starts and ends just after a rising edge.
  task automatic step(input logic [3:0] v, input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input logic [3:0] d3, input logic r);
    int data [4];
    int w;
    bit found;
    bit ld;
    logic [3:0] exp_rdy;
    bus.in_valid = v;
    bus.in_data0 = d0; bus.in_data1 = d1; bus.in_data2 = d2; bus.in_data3 = d3;
    bus.out_ready = r;
    data[0] = int'(d0); data[1] = int'(d1); data[2] = int'(d2); data[3] = int'(d3);
    w = m_ptr;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (!found && v[j]) begin
        w = j;
        found = 1;
      end
    end
    ld = found && (m_ov == 0 || r);
    exp_rdy = ld ? 4'(1 << w) : 4'b0000;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("sel", 32'(bus.sel), 32'(w));
    @(posedge clk);
    if (ld) begin
      m_od = data[w]; m_os = w; m_ov = 1;
      m_ptr = (w + 1) % 4;
      m_cnt = (m_cnt + 1) % 256;
    end else if (m_ov != 0 && r) begin
      m_ov = 0;
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data", 32'(bus.out_data), 32'(m_od));
    chk("out_src", 32'(bus.out_src), 32'(m_os));
    chk("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
    $display("xfer v=%b r=%b rdy=%b ov=%0d src=%0d data=%h cnt=%0d",
             v, r, exp_rdy, bus.out_valid, bus.out_src, bus.out_data, bus.xfer_count);
  endtask

  initial begin
    int guard;
    reset_n = 1'b1;
    bus.in_valid = 4'h0;
    bus.in_data0 = 4'h0; bus.in_data1 = 4'h0; bus.in_data2 = 4'h0; bus.in_data3 = 4'h0;
    bus.out_ready = 1'b0;
    #1;
    apply_reset();

    // Single requester
    step(4'b0100, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1);
    chk("single_data", 32'(bus.out_data), 32'hA);
    chk("single_src", 32'(bus.out_src), 2);
    chk_ptr("single_ptr");

    // Full rotation from ptr=0
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
      chk("rot_src", 32'(bus.out_src), 32'(i % 4));
      chk("rot_data", 32'(bus.out_data), 32'(i % 4 + 1));
    end
    chk("rot_count", 32'(bus.xfer_count), 8);

    // Backpressure: hold 5 from source 1, then stall
    step(4'b0010, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 4'h7, 4'h0, 4'h0, 4'h9, 1'b0);
      chk("bp_hold_data", 32'(bus.out_data), 32'h5);
    end
    chk_ptr("bp_ptr");
    step(4'b1001, 4'h7, 4'h0, 4'h0, 4'h9, 1'b1);
    chk("bp_release_src", 32'(bus.out_src), 3);

    // Pointer wrap, then drain
    step(4'b0100, 4'h0, 4'h0, 4'h6, 4'h0, 1'b1);
    step(4'b1001, 4'hC, 4'h0, 4'h0, 4'hD, 1'b1);
    chk("wrap_src3", 32'(bus.out_src), 3);
    step(4'b1001, 4'hC, 4'h0, 4'h0, 4'hD, 1'b1);
    chk("wrap_src0", 32'(bus.out_src), 0);
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_data", 32'(bus.out_data), 32'hC);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    // Counter preload to 255, then wrap
    guard = 0;
    while (m_cnt != 255 && guard < 300) begin
      step(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
      guard++;
    end
    chk("cnt_preload", 32'(bus.xfer_count), 255);
    step(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    chk("cnt_wrap", 32'(bus.xfer_count), 0);
    chk("pre_async_valid", 32'(bus.out_valid), 1);

    // Asynchronous reset between edges while FULL
    bus.in_valid = 4'hF;
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_in_ready", 32'(bus.in_ready), 0);
    chk("async_xfer_count", 32'(bus.xfer_count), 0);
    reset_n = 1'b1;
    bus.in_valid = 4'h0;
    #1;
    chk("async_ptr", 32'(bus.sel), 0);
    step(4'b0010, 4'h0, 4'hB, 4'h0, 4'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end
endmodule
